// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, FSM states and
// flag-bit positions inside the {C,V,N,Z} nibble.
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_XOR   = 3'b100;
  localparam logic [2:0] OP_NOT   = 3'b101;
  localparam logic [2:0] OP_ZERO0 = 3'b110;
  localparam logic [2:0] OP_ZERO1 = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } seq_state_t;

  localparam int unsigned FLAG_C = 3;
  localparam int unsigned FLAG_V = 2;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_Z = 0;

  function automatic logic [3:0] pack_flags(input logic c, input logic v,
                                            input logic n, input logic z);
    logic [3:0] f;
    f         = '0;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    return f;
  endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// Register file for the sequencer: two combinational read ports, one
// synchronous write port, synchronous clear of every entry on reset.
module alu_seq_regfile
  import alu_seq_pkg::*;
#(
  parameter int unsigned NREGS = 8,
  parameter int unsigned WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_we,
  input  logic [$clog2(NREGS)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(NREGS)-1:0] i_raddr_a,
  output logic [WIDTH-1:0]         o_rdata_a,
  input  logic [$clog2(NREGS)-1:0] i_raddr_b,
  output logic [WIDTH-1:0]         o_rdata_b
);

  logic [WIDTH-1:0] r_regs [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_regs[i_raddr_a];
  assign o_rdata_b = r_regs[i_raddr_b];

endmodule

// File: rtl/alu_sequencer.sv
// Command front-end for the external 16-bit ALU: reads operands from the
// register file, captures result and flags, writes back and responds.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned NREGS = 8,
  parameter int unsigned WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_ld,
  input  logic [2:0]               cmd_op,
  input  logic [$clog2(NREGS)-1:0] cmd_rd,
  input  logic [$clog2(NREGS)-1:0] cmd_ra,
  input  logic [$clog2(NREGS)-1:0] cmd_rb,
  input  logic [WIDTH-1:0]         cmd_imm,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [WIDTH-1:0]         res_data,
  output logic [3:0]               res_flags,
  output logic [3:0]               status,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [2:0]               alu_op,
  input  logic [WIDTH-1:0]         alu_y,
  input  logic                     alu_c,
  input  logic                     alu_v,
  input  logic                     alu_n,
  input  logic                     alu_z
);

  localparam int unsigned AW = $clog2(NREGS);

  seq_state_t       r_state;
  seq_state_t       w_state_nxt;
  logic             w_accept;
  logic             w_wb_en;

  logic             r_ld;
  logic [AW-1:0]    r_rd;
  logic [WIDTH-1:0] r_imm;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [2:0]       r_alu_op;
  logic [WIDTH-1:0] r_res_data;
  logic [3:0]       r_res_flags;
  logic [3:0]       r_status;

  logic [WIDTH-1:0] w_rdata_a;
  logic [WIDTH-1:0] w_rdata_b;
  logic [WIDTH-1:0] w_wdata;
  logic [3:0]       w_alu_flags;

  assign w_alu_flags = pack_flags(alu_c, alu_v, alu_n, alu_z);
  assign w_wdata     = r_ld ? r_imm : alu_y;

  alu_seq_regfile #(
    .NREGS (NREGS),
    .WIDTH (WIDTH)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_wb_en),
    .i_waddr   (r_rd),
    .i_wdata   (w_wdata),
    .i_raddr_a (cmd_ra),
    .o_rdata_a (w_rdata_a),
    .i_raddr_b (cmd_rb),
    .o_rdata_b (w_rdata_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Gating with rst keeps cmd_ready low in the reset cycle and suppresses
  // writeback when reset lands on the EXEC edge.
  always_comb begin
    w_state_nxt = r_state;
    cmd_ready   = 1'b0;
    res_valid   = 1'b0;
    w_accept    = 1'b0;
    w_wb_en     = 1'b0;
    case (r_state)
      IDLE: begin
        cmd_ready = ~rst;
        w_accept  = cmd_valid & ~rst;
        if (w_accept) begin
          w_state_nxt = EXEC;
        end
      end
      EXEC: begin
        w_wb_en     = ~rst;
        w_state_nxt = RESP;
      end
      RESP: begin
        res_valid = 1'b1;
        if (res_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operands are captured at accept time, so a same-register destination
  // always sees the pre-command value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ld        <= 1'b0;
      r_rd        <= '0;
      r_imm       <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_op    <= OP_ADD;
      r_res_data  <= '0;
      r_res_flags <= '0;
      r_status    <= '0;
    end else begin
      if (w_accept) begin
        r_ld  <= cmd_ld;
        r_rd  <= cmd_rd;
        r_imm <= cmd_imm;
        if (!cmd_ld) begin
          r_alu_a  <= w_rdata_a;
          r_alu_b  <= w_rdata_b;
          r_alu_op <= cmd_op;
        end
      end
      if (r_state == EXEC) begin
        if (r_ld) begin
          r_res_data  <= r_imm;
          r_res_flags <= r_status;
        end else begin
          r_res_data  <= alu_y;
          r_res_flags <= w_alu_flags;
          r_status    <= w_alu_flags;
        end
      end
    end
  end

  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_op    = r_alu_op;
  assign res_data  = r_res_data;
  assign res_flags = r_res_flags;
  assign status    = r_status;

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Sequential command front-end that owns the operand side of the 16-bit ALU. It accepts register-to-register commands over a valid/ready handshake and reads operands from an internal 8×16 register file. It presents them to the ALU (`alu_a`, `alu_b`, `alu_op`), captures the result and C/V/N/Z flags, writes the result back, and returns it on a valid/ready response channel.

## Interface

Parameters:
- `NREGS`, default 8: register-file depth. Fixed at 8; index width is 3.
- `WIDTH`, default 16: datapath width. Must match the ALU.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `cmd_valid`, in, 1: command present.
- `cmd_ready`, out, 1: sequencer can accept a command.
- `cmd_ld`, in, 1: 1 = load immediate into `rd`; 0 = ALU operation.
- `cmd_op`, in, 3: ALU opcode. ADD=000, SUB=001, AND=010, OR=011, XOR=100, NOT=101, 110/111 = zero op.
- `cmd_rd`, in, 3: destination register.
- `cmd_ra`, in, 3: source register A.
- `cmd_rb`, in, 3: source register B.
- `cmd_imm`, in, 16: immediate value for `cmd_ld`.
- `res_valid`, out, 1: response present.
- `res_ready`, in, 1: consumer accepts the response.
- `res_data`, out, 16: result written to `rd`.
- `res_flags`, out, 4: {C,V,N,Z} for this command.
- `status`, out, 4: persistent {C,V,N,Z} status register.
- `alu_a`, out, 16: ALU operand A.
- `alu_b`, out, 16: ALU operand B.
- `alu_op`, out, 3: ALU opcode.
- `alu_y`, in, 16: ALU result.
- `alu_c`, `alu_v`, `alu_n`, `alu_z`, in, 1 each: ALU flags.

## Operation

- FSM states are IDLE, EXEC and RESP.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`&&`cmd_ready`, latch the command.
  - For ALU commands, register `regs[ra]` → `alu_a`, `regs[rb]` → `alu_b`, `cmd_op` → `alu_op`.
  - Go to EXEC.
- EXEC (one cycle):
  - ALU commands: sample `alu_y` and flags at the end of the cycle. Write `alu_y` → `regs[rd]` and `{c,v,n,z}` → `status`. Load `res_data`/`res_flags` with the same values.
  - `cmd_ld`: write `cmd_imm` → `regs[rd]`. `res_data`=imm, `res_flags`=current `status`. `status` is unchanged, and `alu_a/b/op` hold their previous values.
  - Go to RESP.
- RESP:
  - `res_valid`=1; `res_data` and `res_flags` are held stable.
  - On `res_ready`, go to IDLE.
  - `cmd_ready`=0 in EXEC and RESP.
- Operand reads use the pre-command register value, including when `ra`==`rd` or `rb`==`rd`.
- Ops 110/111 are accepted and passed to the ALU. The ALU returns Y=0, flags {0,0,0,1}, and the sequencer writes them unmodified.
- The sequencer never alters flags: logic ops leave C=V=N=0 exactly as the ALU reports them.
- NOT ignores `rb`; `alu_b` is still driven from `regs[rb]`.
- Register 0 is general purpose (not hardwired to zero).

## Timing

- Command accepted at edge k; EXEC is cycle k+1; `res_valid` is high from cycle k+2.
- Minimum issue interval is 3 cycles (back-to-back with `res_ready` tied high).
- `alu_a/b/op` are stable for the whole EXEC cycle. The ALU is purely combinational, so no ALU handshake exists.
- Backpressure: `res_valid` stays high and `res_data`/`res_flags`/`status` stay stable until `res_ready`. No new command is accepted meanwhile.
- `cmd_*` fields are don't-care whenever `cmd_valid`=0 or `cmd_ready`=0.
- Reset:
  - Values: state=IDLE, `cmd_ready`=0 during the reset cycle and 1 from the first cycle after. `res_valid`=0, `res_data`=0, `res_flags`=0, `status`=0, `alu_a`=`alu_b`=0, `alu_op`=000, all registers 0.
  - Mid-operation reset (EXEC or RESP) discards the command. There is no writeback if reset coincides with the EXEC edge, and any pending response is dropped.

## Structure

- Package `alu_seq_pkg`:
  - opcode constants OP_ADD…OP_NOT, OP_ZERO0/1;
  - state enum `seq_state_t` {IDLE, EXEC, RESP};
  - flag bit indices FLAG_C=3, FLAG_V=2, FLAG_N=1, FLAG_Z=0.
- Sub-module `alu_seq_regfile`: 8×16 register file with 2 combinational read ports, 1 synchronous write port and synchronous reset to 0.
- The ALU is instantiated beside the sequencer at the parent level, not inside it.

## Test plan

- LDI r1=0x7FFF, LDI r2=0x0001, ADD r3=r1+r2 → `res_data`=0x8000, `res_flags`=C0 V1 N1 Z0, `status`=0b0110, `regs[3]`=0x8000.
- LDI r4=0x0005, SUB r5=r4−r4 → `res_data`=0x0000, flags C0 V0 N0 Z1. Then LDI r6=0x1234 → `res_flags`=0b0001, `status` unchanged.
- LDI r1=0xFFFF, AND r2=r1&r1 → 0xFFFF, flags 0b0000 (N=0 for logic op). NOT r3=~r1 → 0x0000, flags 0b0001.
- ADD r1=r1+r1 with r1=0x4000 → 0x8000, checking that the old operand value is used and writeback lands in the same register.
- Hold `res_ready`=0 for 5 cycles in RESP → `res_valid`, `res_data`, `res_flags` stable, `cmd_ready`=0, and a command offered during the stall is not accepted.
- Assert `rst` during EXEC of ADD r7 → `regs[7]`=0, `status`=0, `res_valid`=0. The next cycle after reset has `cmd_ready`=1.
